// File: rtl/common.sv
// Shared definitions for the CPU control path: sequencer state encoding,
// address-source select values and ALU operation codes.
package common_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_t;

    localparam logic ADDR_IP  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_NOT    = 4'd5,
        ALU_SHL    = 4'd6,
        ALU_SHR    = 4'd7,
        ALU_PASS_A = 4'd8,
        ALU_PASS_B = 4'd9
    } alu_sel_t;

    // A data access happens only when exactly one direction is requested.
    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch / decode / execute / commit with memory
// wait handling, bus-error timeout, halt control and gated commit strobes.
module cpu_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic halt_req,
    input  logic mem_ready,
    input  logic rd_mem,
    input  logic wr_mem,
    input  logic byt,
    input  logic load_stk,
    input  logic load_fp,
    input  logic load_ip,
    input  logic push,
    input  logic pop,
    input  logic cpush,
    input  logic cpop,
    input  logic wr_stk1,
    output logic mem_req,
    output logic mem_we,
    output logic mem_byt,
    output logic addr_sel,
    output logic load_insn,
    output logic ip_inc,
    output logic stk_we,
    output logic fp_we,
    output logic ip_we,
    output logic stk_push,
    output logic stk_pop,
    output logic cstk_push,
    output logic cstk_pop,
    output logic stk1_we,
    output logic halted,
    output logic bus_err,
    output logic illegal
);
    import common_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_t       state_reg;
    logic             run_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             bus_err_reg;
    logic             illegal_reg;

    logic mem_op;
    logic rw_both;
    logic commit_en;
    logic waiting;
    logic wait_expired;

    always_comb begin
        mem_op       = is_mem_op(rd_mem, wr_mem);
        rw_both      = rd_mem & wr_mem;
        // run_reg keeps the request low until the first edge after reset.
        mem_req      = run_reg && ((state_reg == ST_FETCH) ||
                                   (state_reg == ST_EXEC && mem_op));
        mem_we       = mem_req && (state_reg == ST_EXEC) && wr_mem;
        mem_byt      = mem_req && (state_reg == ST_EXEC) && byt;
        addr_sel     = (mem_req && state_reg == ST_EXEC) ? ADDR_ALU : ADDR_IP;
        load_insn    = mem_req && (state_reg == ST_FETCH) && mem_ready;
        ip_inc       = load_insn;
        waiting      = mem_req && !mem_ready;
        wait_expired = waiting && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

        commit_en = (state_reg == ST_COMMIT) ||
                    (state_reg == ST_EXEC && !rd_mem && !wr_mem);
        stk_we    = commit_en && load_stk;
        fp_we     = commit_en && load_fp;
        ip_we     = commit_en && load_ip;
        stk_push  = commit_en && push;
        stk_pop   = commit_en && pop;
        cstk_push = commit_en && cpush;
        cstk_pop  = commit_en && cpop;
        stk1_we   = commit_en && wr_stk1;

        halted  = (state_reg == ST_HALT);
        bus_err = bus_err_reg;
        illegal = illegal_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_FETCH;
            run_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            bus_err_reg  <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            // Counter only survives consecutive wait cycles, so every new request starts at zero.
            if (waiting && !wait_expired)
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            else
                wait_cnt_reg <= '0;

            if (wait_expired) begin
                bus_err_reg <= 1'b1;
                state_reg   <= ST_HALT;
            end else begin
                case (state_reg)
                    ST_FETCH: begin
                        if (load_insn)
                            state_reg <= ST_DECODE;
                    end
                    ST_DECODE: state_reg <= ST_EXEC;
                    ST_EXEC: begin
                        if (rw_both) begin
                            illegal_reg <= 1'b1;
                            state_reg   <= halt_req ? ST_HALT : ST_FETCH;
                        end else if (mem_op) begin
                            if (mem_ready)
                                state_reg <= ST_COMMIT;
                        end else begin
                            state_reg <= halt_req ? ST_HALT : ST_FETCH;
                        end
                    end
                    ST_COMMIT: state_reg <= halt_req ? ST_HALT : ST_FETCH;
                    ST_HALT: begin
                        if (!halt_req && !bus_err_reg)
                            state_reg <= ST_FETCH;
                    end
                    default: state_reg <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Cycle-by-cycle scoreboard bench for cpu_sequencer with hand-computed vectors.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst, halt_req, mem_ready, rd_mem, wr_mem, byt;
    logic load_stk, load_fp, load_ip, push, pop, cpush, cpop, wr_stk1;
    logic mem_req, mem_we, mem_byt, addr_sel, load_insn, ip_inc;
    logic stk_we, fp_we, ip_we, stk_push, stk_pop, cstk_push, cstk_pop, stk1_we;
    logic halted, bus_err, illegal;

    cpu_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .mem_ready(mem_ready),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .byt(byt),
        .load_stk(load_stk), .load_fp(load_fp), .load_ip(load_ip),
        .push(push), .pop(pop), .cpush(cpush), .cpop(cpop), .wr_stk1(wr_stk1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byt(mem_byt), .addr_sel(addr_sel),
        .load_insn(load_insn), .ip_inc(ip_inc),
        .stk_we(stk_we), .fp_we(fp_we), .ip_we(ip_we), .stk_push(stk_push),
        .stk_pop(stk_pop), .cstk_push(cstk_push), .cstk_pop(cstk_pop), .stk1_we(stk1_we),
        .halted(halted), .bus_err(bus_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } item_t;

    item_t sb_q[$];
    int    total = 0;
    int    bad   = 0;

    // mem = {rd_mem, wr_mem, byt}
    // cmt = {load_stk, load_fp, load_ip, push, pop, cpush, cpop, wr_stk1}
    // req = {mem_req, mem_we, mem_byt, addr_sel, load_insn, ip_inc}
    // stb = {stk_we, fp_we, ip_we, stk_push, stk_pop, cstk_push, cstk_pop, stk1_we}
    // st  = {halted, bus_err, illegal}
    task automatic step(input string name, input logic r, input logic h, input logic rdy,
                        input logic [2:0] mem, input logic [7:0] cmt,
                        input logic [5:0] req, input logic [7:0] stb, input logic [2:0] st);
        item_t it;
        @(posedge clk);
        #1;
        rst       = r;
        halt_req  = h;
        mem_ready = rdy;
        {rd_mem, wr_mem, byt} = mem;
        {load_stk, load_fp, load_ip, push, pop, cpush, cpop, wr_stk1} = cmt;
        it.name = name;
        it.exp  = {req, stb, st};
        sb_q.push_back(it);
    endtask

    always @(negedge clk) begin
        logic [16:0] act;
        item_t it;
        if (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = {mem_req, mem_we, mem_byt, addr_sel, load_insn, ip_inc,
                   stk_we, fp_we, ip_we, stk_push, stk_pop, cstk_push, cstk_pop, stk1_we,
                   halted, bus_err, illegal};
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", it.name, act, it.exp);
            end else begin
                $display("ok   %s: %b", it.name, act);
            end
        end
    end

    localparam logic [2:0] M_NONE = 3'b000, M_RD = 3'b100, M_WRB = 3'b011, M_BOTH = 3'b110;
    localparam logic [7:0] C_INC = 8'h80, C_LD = 8'h90, C_STA = 8'h89, C_ALL = 8'hFF;
    localparam logic [5:0] R_NONE = 6'b000000, R_FETCH = 6'b100011, R_FWAIT = 6'b100000;
    localparam logic [5:0] R_RDW = 6'b100100, R_WRB = 6'b111100;

    initial begin
        rst = 1'b1; halt_req = 1'b0; mem_ready = 1'b0;
        {rd_mem, wr_mem, byt} = 3'b000;
        {load_stk, load_fp, load_ip, push, pop, cpush, cpop, wr_stk1} = 8'h00;

        step("rst_hold0",   1, 0, 0, M_NONE, C_ALL, R_NONE,  8'h00, 3'b000);
        step("rst_hold1",   1, 0, 1, M_NONE, C_ALL, R_NONE,  8'h00, 3'b000);
        step("post_rst",    0, 0, 1, M_NONE, C_ALL, R_NONE,  8'h00, 3'b000);
        // inc, zero wait states
        step("inc_fetch",   0, 0, 1, M_NONE, C_ALL, R_FETCH, 8'h00, 3'b000);
        step("inc_decode",  0, 0, 1, M_NONE, C_INC, R_NONE,  8'h00, 3'b000);
        step("inc_exec",    0, 0, 1, M_NONE, C_INC, R_NONE,  8'h80, 3'b000);
        // ld with two wait states
        step("ld_fetch",    0, 0, 1, M_NONE, C_ALL, R_FETCH, 8'h00, 3'b000);
        step("ld_decode",   0, 0, 1, M_RD,   C_LD,  R_NONE,  8'h00, 3'b000);
        step("ld_wait1",    0, 0, 0, M_RD,   C_LD,  R_RDW,   8'h00, 3'b000);
        step("ld_wait2",    0, 0, 0, M_RD,   C_LD,  R_RDW,   8'h00, 3'b000);
        step("ld_done",     0, 0, 1, M_RD,   C_LD,  R_RDW,   8'h00, 3'b000);
        step("ld_commit",   0, 0, 1, M_RD,   C_LD,  R_NONE,  8'h90, 3'b000);
        // byte store, zero wait states
        step("sta_fetch",   0, 0, 1, M_NONE, C_ALL, R_FETCH, 8'h00, 3'b000);
        step("sta_decode",  0, 0, 1, M_WRB,  C_STA, R_NONE,  8'h00, 3'b000);
        step("sta_access",  0, 0, 1, M_WRB,  C_STA, R_WRB,   8'h00, 3'b000);
        step("sta_commit",  0, 0, 1, M_WRB,  C_STA, R_NONE,  8'h89, 3'b000);
        // rd and wr together
        step("ill_fetch",   0, 0, 1, M_NONE, C_ALL, R_FETCH, 8'h00, 3'b000);
        step("ill_decode",  0, 0, 1, M_BOTH, C_ALL, R_NONE,  8'h00, 3'b000);
        step("ill_exec",    0, 0, 1, M_BOTH, C_ALL, R_NONE,  8'h00, 3'b000);
        step("ill_refetch", 0, 0, 1, M_NONE, C_ALL, R_FETCH, 8'h00, 3'b001);
        // halt request raised before commit; not sampled in DECODE
        step("hlt_decode",  0, 1, 1, M_NONE, C_INC, R_NONE,  8'h00, 3'b001);
        step("hlt_exec",    0, 1, 1, M_NONE, C_INC, R_NONE,  8'h80, 3'b001);
        step("halted1",     0, 1, 1, M_NONE, C_ALL, R_NONE,  8'h00, 3'b101);
        step("halted2",     0, 0, 1, M_NONE, C_ALL, R_NONE,  8'h00, 3'b101);
        step("resume",      0, 0, 1, M_NONE, C_ALL, R_FETCH, 8'h00, 3'b001);
        // reset in the middle of a data wait
        step("rw_decode",   0, 0, 1, M_RD,   C_LD,  R_NONE,  8'h00, 3'b001);
        step("rw_wait",     0, 0, 0, M_RD,   C_LD,  R_RDW,   8'h00, 3'b001);
        step("rw_reset",    1, 0, 0, M_RD,   C_LD,  R_NONE,  8'h00, 3'b000);
        step("rw_release",  0, 0, 0, M_RD,   C_LD,  R_NONE,  8'h00, 3'b000);
        step("rw_refetch",  0, 0, 1, M_NONE, C_ALL, R_FETCH, 8'h00, 3'b000);
        step("rw_decode2",  0, 0, 1, M_NONE, 8'h00, R_NONE,  8'h00, 3'b000);
        step("rw_exec2",    0, 0, 1, M_NONE, 8'h00, R_NONE,  8'h00, 3'b000);
        // mem_ready stuck low with TIMEOUT=4
        step("to_w1",       0, 0, 0, M_NONE, C_ALL, R_FWAIT, 8'h00, 3'b000);
        step("to_w2",       0, 0, 0, M_NONE, C_ALL, R_FWAIT, 8'h00, 3'b000);
        step("to_w3",       0, 0, 0, M_NONE, C_ALL, R_FWAIT, 8'h00, 3'b000);
        step("to_w4",       0, 0, 0, M_NONE, C_ALL, R_FWAIT, 8'h00, 3'b000);
        step("to_halt",     0, 0, 1, M_NONE, C_ALL, R_NONE,  8'h00, 3'b110);
        step("to_stuck1",   0, 0, 1, M_NONE, C_ALL, R_NONE,  8'h00, 3'b110);
        step("to_stuck2",   0, 0, 0, M_NONE, C_ALL, R_NONE,  8'h00, 3'b110);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(posedge clk);
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum wait cycles on mem_ready before a bus error.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 halt_req  in  1  request to stop at the next instruction boundary.
REQ-005 mem_ready  in  1  memory completes the current access this cycle.
REQ-006 rd_mem, wr_mem, byt  in  1 each  memory controls from the decoder.
REQ-007 load_stk, load_fp, load_ip, push, pop, cpush, cpop, wr_stk1  in  1 each  commit controls from the decoder.
REQ-008 mem_req  out  1  memory access request.
REQ-009 mem_we  out  1  write access.
REQ-010 mem_byt  out  1  byte access.
REQ-011 addr_sel  out  1  address source: 0 = ip, 1 = ALU result.
REQ-012 load_insn  out  1  latch the fetched word into the instruction register.
REQ-013 ip_inc  out  1  ip += 2.
REQ-014 stk_we, fp_we, ip_we, stk_push, stk_pop, cstk_push, cstk_pop, stk1_we  out  1 each  gated commit strobes.
REQ-015 halted, bus_err, illegal  out  1 each  status outputs.

Function
REQ-016 The state machine SHALL have the states FETCH, DECODE, EXEC, COMMIT and HALT.
REQ-017 FETCH SHALL hold mem_req=1, mem_we=0, mem_byt=0, addr_sel=0 until mem_ready=1. In that cycle it SHALL pulse load_insn and ip_inc and go to DECODE.
REQ-018 DECODE SHALL last exactly 1 cycle with all strobes 0, then go to EXEC.
REQ-019 In EXEC with rd_mem=0 and wr_mem=0, the sequencer SHALL pulse each commit strobe equal to its decoder input for 1 cycle, then go to FETCH.
REQ-020 In EXEC with exactly one of rd_mem or wr_mem set, it SHALL hold mem_req=1, addr_sel=1, mem_we=wr_mem, mem_byt=byt until mem_ready=1, then go to COMMIT.
REQ-021 COMMIT SHALL pulse the commit strobes from the decoder inputs for 1 cycle, then go to FETCH.
REQ-022 All request attributes SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-023 mem_ready=1 in the same cycle a request is first asserted SHALL complete the access (zero wait states).
REQ-024 mem_ready while mem_req=0 SHALL be ignored.
REQ-025 rd_mem=1 and wr_mem=1 together SHALL set illegal (sticky), suppress all commit strobes, and go to FETCH.
REQ-026 A wait counter SHALL clear on each new request and increment per wait cycle.
REQ-027 Reaching TIMEOUT SHALL drop mem_req, set bus_err (sticky), and go to HALT.
REQ-028 halt_req SHALL be sampled only when leaving EXEC or COMMIT toward FETCH. If set, the next state is HALT.
REQ-029 HALT SHALL assert halted=1 with all strobes and mem_req 0.
REQ-030 HALT SHALL exit to FETCH when halt_req=0 and bus_err=0. Only reset clears bus_err.
REQ-031 A commit strobe SHALL never be asserted in the same cycle as load_insn.
REQ-032 Instruction latency SHALL be 3 cycles without memory operands and 4 cycles with them, at zero wait states.

Reset
REQ-033 Asserting rst SHALL immediately force state FETCH, counter 0, and all outputs 0 except mem_req, which goes 1 after the first post-reset edge.
REQ-034 Reset mid-access SHALL abandon the access, and no strobe SHALL fire for the interrupted instruction.

Structure
REQ-035 The state encoding and the ADDR_IP/ADDR_ALU constants SHALL live in common.sv alongside the ALU select codes.
REQ-036 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-037 Inc, mem_ready held 1 (0 wait states) -> load_insn at cycle 0, stk_we pulse at cycle 2, next mem_req at FETCH in cycle 3.
REQ-038 Ld with rd_mem=1 and 2 wait states -> mem_req/addr_sel=1 for 3 cycles, then stk_we+stk_push in COMMIT.
REQ-039 Sta -> mem_we=1 during access, then stk1_we+stk_pop+stk_we pulse together.
REQ-040 rd_mem=wr_mem=1 -> illegal=1, no strobes, next FETCH.
REQ-041 mem_ready stuck 0 with TIMEOUT=4 -> bus_err=1 and halted=1 after 4 wait cycles; halt_req=0 does not exit.
REQ-042 halt_req raised during EXEC -> halted=1 after commit; halt_req dropped -> FETCH resumes.
REQ-043 rst pulsed mid-wait -> all strobes 0 and state FETCH restarts cleanly.
